// File: rtl/store_unit_pkg.sv
// -----------------------------------------------------------------------------
// store_unit_pkg
// Shared definitions for the load/store data path:
//   - funct3 encodings for loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW)
//   - store_state_e : sequencing states of the store unit
//   - store_size_mask() : right-justified byte-lane mask for a store funct3
// -----------------------------------------------------------------------------
package store_unit_pkg;

    // Load encodings, kept here so the load and store paths share one source.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings.
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } store_state_e;

    // Byte mask before lane shifting: SB -> 0001, SH -> 0011, SW -> 1111.
    // Any other funct3 returns 0, which callers treat as an illegal store.
    function automatic logic [3:0] store_size_mask(input logic [2:0] f3);
        logic [3:0] m;
        m = 4'b0000;
        case (f3)
            F3_SB:   m = 4'b0001;
            F3_SH:   m = 4'b0011;
            F3_SW:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// -----------------------------------------------------------------------------
// store_unit_if
// Bundles the store request side (from MEM stage) and the data-memory write
// side of the store unit.
//   request : req_valid, req_ready, funct3, addr, wdata
//   memory  : dm_req, dm_addr, dm_wdata, dm_strb, dm_gnt
//   status  : done, err
// Modports:
//   slave  - the store unit itself
//   master - the environment (pipeline + memory) driving the unit
// -----------------------------------------------------------------------------
interface store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;

    logic              dm_req;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [3:0]        dm_strb;
    logic              dm_gnt;

    logic              done;
    logic              err;

    modport slave (
        input  req_valid, funct3, addr, wdata, dm_gnt,
        output req_ready, dm_req, dm_addr, dm_wdata, dm_strb, done, err
    );

    modport master (
        output req_valid, funct3, addr, wdata, dm_gnt,
        input  req_ready, dm_req, dm_addr, dm_wdata, dm_strb, done, err
    );

endinterface

// File: rtl/store_lane_gen.sv
// -----------------------------------------------------------------------------
// store_lane_gen
// Combinational lane generator for stores. Given the store type, the byte
// offset within the word and right-justified data, produces the byte-lane
// mask and lane-shifted data across two consecutive words.
//   funct3  in  store type (SB/SH/SW)
//   offset  in  addr[1:0]
//   wdata   in  rs2 data, right-justified
//   mask    out lane mask, [3:0] first word, [7:4] following word
//   data    out shifted data, [31:0] first word, [63:32] following word;
//               lanes outside the mask are zero
//   split   out store touches the following word
//   illegal out funct3 is not a store encoding (mask/data are zero)
// -----------------------------------------------------------------------------
module store_lane_gen
    import store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic [7:0]  mask,
    output logic [63:0] data,
    output logic        split,
    output logic        illegal
);

    logic [3:0]  size_mask;
    logic [63:0] shifted;

    always_comb begin
        size_mask = store_size_mask(funct3);
        illegal   = (size_mask == 4'b0000);
        mask      = {4'b0000, size_mask} << offset;
        shifted   = {32'b0, wdata} << {offset, 3'b000};
        split     = |mask[7:4];

        // Upper rs2 bytes of SB/SH would otherwise leak into unwritten lanes.
        data = '0;
        for (int b = 0; b < 8; b++) begin
            data[8*b +: 8] = mask[b] ? shifted[8*b +: 8] : 8'h00;
        end
    end

endmodule

// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit
// Turns one store request into one or two word-aligned data-memory writes
// with byte strobes. Stores crossing a word boundary are issued as two
// back-to-back writes (SPLIT_EN=1) or rejected with err (SPLIT_EN=0).
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | req_ready=1, waiting for a request; dm_req=0
//   FIRST  | first (or only) word write presented, waiting for dm_gnt
//   SECOND | second word write of a split store presented, waiting for dm_gnt
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active-high
//   bus  - store_unit_if.slave (request, memory and status signals)
// All memory-side outputs and done/err are registered; req_ready decodes the
// state register so it returns to 1 together with the done pulse.
// -----------------------------------------------------------------------------
module store_unit
    import store_unit_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1,
    parameter int ADDR_W   = 32
) (
    input  logic        clk,
    input  logic        rst,
    store_unit_if.slave bus
);

    store_state_e      state_q, state_d;

    logic              dm_req_q,   dm_req_d;
    logic [ADDR_W-1:0] dm_addr_q,  dm_addr_d;
    logic [31:0]       dm_wdata_q, dm_wdata_d;
    logic [3:0]        dm_strb_q,  dm_strb_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;

    // Second-beat payload captured at accept so the request inputs can change.
    logic              split_q,    split_d;
    logic [3:0]        hi_strb_q,  hi_strb_d;
    logic [31:0]       hi_wdata_q, hi_wdata_d;

    logic [7:0]        lane_mask;
    logic [63:0]       lane_data;
    logic              lane_split;
    logic              lane_illegal;

    logic              req_ready;
    logic              accept;

    store_lane_gen u_lane_gen (
        .funct3  (bus.funct3),
        .offset  (bus.addr[1:0]),
        .wdata   (bus.wdata),
        .mask    (lane_mask),
        .data    (lane_data),
        .split   (lane_split),
        .illegal (lane_illegal)
    );

    assign req_ready = (state_q == IDLE);
    assign accept    = bus.req_valid && req_ready;

    always_comb begin
        state_d    = state_q;
        dm_req_d   = 1'b0;
        dm_addr_d  = '0;
        dm_wdata_d = '0;
        dm_strb_d  = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        split_d    = split_q;
        hi_strb_d  = hi_strb_q;
        hi_wdata_d = hi_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (lane_illegal || (lane_split && !SPLIT_EN)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = FIRST;
                        dm_req_d   = 1'b1;
                        dm_addr_d  = {bus.addr[ADDR_W-1:2], 2'b00};
                        dm_strb_d  = lane_mask[3:0];
                        dm_wdata_d = lane_data[31:0];
                        split_d    = lane_split;
                        hi_strb_d  = lane_mask[7:4];
                        hi_wdata_d = lane_data[63:32];
                    end
                end
            end

            FIRST: begin
                dm_req_d   = 1'b1;
                dm_addr_d  = dm_addr_q;
                dm_wdata_d = dm_wdata_q;
                dm_strb_d  = dm_strb_q;
                if (bus.dm_gnt) begin
                    if (split_q) begin
                        state_d    = SECOND;
                        // Wraps modulo 2^ADDR_W at the top of the address space.
                        dm_addr_d  = dm_addr_q + ADDR_W'(4);
                        dm_strb_d  = hi_strb_q;
                        dm_wdata_d = hi_wdata_q;
                    end else begin
                        state_d    = IDLE;
                        dm_req_d   = 1'b0;
                        dm_addr_d  = '0;
                        dm_wdata_d = '0;
                        dm_strb_d  = '0;
                        done_d     = 1'b1;
                    end
                end
            end

            SECOND: begin
                dm_req_d   = 1'b1;
                dm_addr_d  = dm_addr_q;
                dm_wdata_d = dm_wdata_q;
                dm_strb_d  = dm_strb_q;
                if (bus.dm_gnt) begin
                    state_d    = IDLE;
                    dm_req_d   = 1'b0;
                    dm_addr_d  = '0;
                    dm_wdata_d = '0;
                    dm_strb_d  = '0;
                    done_d     = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dm_req_q   <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            dm_strb_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            split_q    <= 1'b0;
            hi_strb_q  <= '0;
            hi_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            dm_req_q   <= dm_req_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            dm_strb_q  <= dm_strb_d;
            done_q     <= done_d;
            err_q      <= err_d;
            split_q    <= split_d;
            hi_strb_q  <= hi_strb_d;
            hi_wdata_q <= hi_wdata_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.dm_req    = dm_req_q;
    assign bus.dm_addr   = dm_addr_q;
    assign bus.dm_wdata  = dm_wdata_q;
    assign bus.dm_strb   = dm_strb_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_store_unit.sv
// -----------------------------------------------------------------------------
// tb_store_unit
// Two store units: u_dut0 with SPLIT_EN=1 and u_dut1 with SPLIT_EN=0, driven
// one at a time. A reference model pushes expected write beats into a shared
// queue on accept; a monitor on the falling edge compares every presented
// write against the queue head and pops it on grant. The model also tracks
// beats outstanding per unit to predict req_ready, dm_req, done and err.
// -----------------------------------------------------------------------------
module tb_store_unit;

    localparam int ADDR_W = 32;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } beat_t;

    logic clk;
    logic rst_v       [2];
    logic req_valid_v [2];
    logic [2:0]  funct3_v [2];
    logic [31:0] addr_v   [2];
    logic [31:0] wdata_v  [2];
    logic gnt_v       [2];

    logic        req_ready_v [2];
    logic        dm_req_v    [2];
    logic [31:0] dm_addr_v   [2];
    logic [31:0] dm_wdata_v  [2];
    logic [3:0]  dm_strb_v   [2];
    logic        done_v      [2];
    logic        err_v       [2];

    int    total;
    int    bad;
    int    beats_left [2];
    bit    done_exp   [2];
    bit    err_exp    [2];
    int    gnt_pct    [2];
    int    gnt_hold   [2];
    bit    mon_en;
    beat_t exp_q [$];

    store_unit_if #(.ADDR_W(ADDR_W)) bus0 ();
    store_unit_if #(.ADDR_W(ADDR_W)) bus1 ();

    store_unit #(.SPLIT_EN(1'b1), .ADDR_W(ADDR_W)) u_dut0 (
        .clk (clk),
        .rst (rst_v[0]),
        .bus (bus0)
    );

    store_unit #(.SPLIT_EN(1'b0), .ADDR_W(ADDR_W)) u_dut1 (
        .clk (clk),
        .rst (rst_v[1]),
        .bus (bus1)
    );

    assign bus0.req_valid = req_valid_v[0];
    assign bus0.funct3    = funct3_v[0];
    assign bus0.addr      = addr_v[0];
    assign bus0.wdata     = wdata_v[0];
    assign bus0.dm_gnt    = gnt_v[0];
    assign bus1.req_valid = req_valid_v[1];
    assign bus1.funct3    = funct3_v[1];
    assign bus1.addr      = addr_v[1];
    assign bus1.wdata     = wdata_v[1];
    assign bus1.dm_gnt    = gnt_v[1];

    assign req_ready_v[0] = bus0.req_ready;
    assign dm_req_v[0]    = bus0.dm_req;
    assign dm_addr_v[0]   = bus0.dm_addr;
    assign dm_wdata_v[0]  = bus0.dm_wdata;
    assign dm_strb_v[0]   = bus0.dm_strb;
    assign done_v[0]      = bus0.done;
    assign err_v[0]       = bus0.err;
    assign req_ready_v[1] = bus1.req_ready;
    assign dm_req_v[1]    = bus1.dm_req;
    assign dm_addr_v[1]   = bus1.dm_addr;
    assign dm_wdata_v[1]  = bus1.dm_wdata;
    assign dm_strb_v[1]   = bus1.dm_strb;
    assign done_v[1]      = bus1.done;
    assign err_v[1]       = bus1.err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h, want %0h", name, i, act, exp);
        end
    endtask

    // Reference: walk the stored bytes one at a time into byte lanes of two
    // consecutive words.
    function automatic void build(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] d, input bit split_en,
                                  output bit legal, output int nb,
                                  output beat_t b0, output beat_t b1);
        int n;
        int lane;
        n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : (f3 == 3'b010) ? 4 : 0;
        b0 = '{idx: 0, addr: '0, strb: '0, data: '0};
        b1 = '{idx: 0, addr: '0, strb: '0, data: '0};
        b0.addr = {a[31:2], 2'b00};
        b1.addr = b0.addr + 32'd4;
        for (int k = 0; k < n; k++) begin
            lane = int'(a[1:0]) + k;
            if (lane < 4) begin
                b0.strb[lane]          = 1'b1;
                b0.data[8*lane +: 8]   = d[8*k +: 8];
            end else begin
                b1.strb[lane-4]        = 1'b1;
                b1.data[8*(lane-4) +: 8] = d[8*k +: 8];
            end
        end
        nb    = (b1.strb != 4'b0000) ? 2 : 1;
        legal = (n != 0) && (nb == 1 || split_en);
    endfunction

    // Reference model: evaluated at each rising edge.
    initial begin
        bit    legal;
        int    nb;
        beat_t b0, b1;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_v[i]) begin
                    done_exp[i] = 1'b0;
                    err_exp[i]  = 1'b0;
                    if (beats_left[i] > 0) begin
                        if (gnt_v[i]) begin
                            beats_left[i]--;
                            if (beats_left[i] == 0) done_exp[i] = 1'b1;
                        end
                    end else if (req_valid_v[i]) begin
                        build(funct3_v[i], addr_v[i], wdata_v[i], (i == 0), legal, nb, b0, b1);
                        if (legal) begin
                            b0.idx = i;
                            b1.idx = i;
                            exp_q.push_back(b0);
                            if (nb == 2) exp_q.push_back(b1);
                            beats_left[i] = nb;
                        end else begin
                            err_exp[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Grant generator: optional forced-low hold, otherwise random percentage.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 2; i++) begin
                if (gnt_hold[i] > 0) begin
                    gnt_v[i] = 1'b0;
                    gnt_hold[i]--;
                end else begin
                    gnt_v[i] = ($urandom_range(0, 99) < gnt_pct[i]);
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int i = 0; i < 2; i++) begin
                    if (!rst_v[i]) begin
                        chk("req_ready", i, 64'(req_ready_v[i]), 64'(beats_left[i] == 0));
                        chk("dm_req", i, 64'(dm_req_v[i]), 64'(beats_left[i] > 0));
                        chk("done", i, 64'(done_v[i]), 64'(done_exp[i]));
                        chk("err", i, 64'(err_v[i]), 64'(err_exp[i]));
                        if (dm_req_v[i]) begin
                            if (exp_q.size() == 0 || exp_q[0].idx != i) begin
                                total++;
                                bad++;
                                $display("FAIL beat_unexpected dut%0d: got write to %0h, want no write",
                                         i, dm_addr_v[i]);
                            end else begin
                                chk("dm_addr", i, 64'(dm_addr_v[i]), 64'(exp_q[0].addr));
                                chk("dm_strb", i, 64'(dm_strb_v[i]), 64'(exp_q[0].strb));
                                chk("dm_wdata", i, 64'(dm_wdata_v[i]), 64'(exp_q[0].data));
                                if (gnt_v[i]) void'(exp_q.pop_front());
                            end
                        end else begin
                            chk("dm_strb_idle", i, 64'(dm_strb_v[i]), 64'd0);
                        end
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input int i);
        chk("rst_req_ready", i, 64'(req_ready_v[i]), 64'd1);
        chk("rst_dm_req", i, 64'(dm_req_v[i]), 64'd0);
        chk("rst_dm_addr", i, 64'(dm_addr_v[i]), 64'd0);
        chk("rst_dm_wdata", i, 64'(dm_wdata_v[i]), 64'd0);
        chk("rst_dm_strb", i, 64'(dm_strb_v[i]), 64'd0);
        chk("rst_done", i, 64'(done_v[i]), 64'd0);
        chk("rst_err", i, 64'(err_v[i]), 64'd0);
    endtask

    // Called just after a rising edge; presents the request when both units
    // are expected idle, returns just after the accepting edge.
    task automatic issue(input int i, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input int hold);
        int guard;
        guard = 0;
        while ((beats_left[0] != 0 || beats_left[1] != 0) && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 500) begin
            total++;
            bad++;
            $display("FAIL issue_wait dut%0d: got busy after %0d cycles, want idle", i, guard);
        end
        req_valid_v[i] = 1'b1;
        funct3_v[i]    = f3;
        addr_v[i]      = a;
        wdata_v[i]     = d;
        gnt_hold[i]    = hold;
        @(posedge clk);
        #1;
        req_valid_v[i] = 1'b0;
        funct3_v[i]    = 3'($urandom);
        addr_v[i]      = $urandom;
        wdata_v[i]     = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout at %0t, want completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        int          r;
        int          i;
        int          guard;

        total  = 0;
        bad    = 0;
        mon_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rst_v[k]       = 1'b1;
            req_valid_v[k] = 1'b0;
            funct3_v[k]    = 3'b000;
            addr_v[k]      = '0;
            wdata_v[k]     = '0;
            gnt_v[k]       = 1'b0;
            beats_left[k]  = 0;
            done_exp[k]    = 1'b0;
            err_exp[k]     = 1'b0;
            gnt_pct[k]     = 100;
            gnt_hold[k]    = 0;
        end

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        mon_en   = 1'b1;

        // Single-beat SB into the top lane.
        issue(0, 3'b000, 32'h0000_1003, 32'h1234_5678, 0);
        // Split SH across a word boundary.
        issue(0, 3'b001, 32'h0000_2003, 32'h0000_ABCD, 0);
        // SW with grant held low for several cycles.
        issue(0, 3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 4);
        // Split SW wrapping past the top of the address space.
        issue(0, 3'b010, 32'hFFFF_FFFE, 32'hAABB_CCDD, 0);
        // Illegal funct3 on both units; boundary-crossing SH on the no-split unit.
        issue(0, 3'b011, 32'h0000_0040, 32'h0102_0304, 0);
        issue(1, 3'b011, 32'h0000_0040, 32'h0102_0304, 0);
        issue(1, 3'b001, 32'h0000_0003, 32'h0000_5A5A, 0);
        issue(1, 3'b001, 32'h0000_0001, 32'h0000_5A5A, 0);
        issue(1, 3'b010, 32'h0000_0001, 32'h1111_2222, 0);
        issue(1, 3'b010, 32'h0000_0100, 32'h1111_2222, 2);

        // Asynchronous reset while the second beat of a split store waits.
        issue(0, 3'b001, 32'h0000_2003, 32'h0000_ABCD, 0);
        @(posedge clk);
        #1;
        gnt_pct[0] = 0;
        @(negedge clk);
        chk("pre_rst_dm_addr", 0, 64'(dm_addr_v[0]), 64'h2004);
        #2;
        rst_v[0]      = 1'b1;
        beats_left[0] = 0;
        done_exp[0]   = 1'b0;
        err_exp[0]    = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs(0);
        @(posedge clk);
        #1;
        rst_v[0]   = 1'b0;
        gnt_pct[0] = 100;
        issue(0, 3'b000, 32'h0000_0502, 32'hCAFE_F00D, 0);

        // Randomized traffic on both units.
        for (int n = 0; n < 300; n++) begin
            i = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            if (r < 3)       f3 = 3'b000;
            else if (r < 6)  f3 = 3'b001;
            else if (r < 9)  f3 = 3'b010;
            else             f3 = 3'($urandom_range(3, 7));
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            gnt_pct[i] = $urandom_range(30, 100);
            issue(i, f3, a, $urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #0;
        end

        gnt_pct[0] = 100;
        gnt_pct[1] = 100;
        guard = 0;
        while ((beats_left[0] != 0 || beats_left[1] != 0) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) begin
            total++;
            bad++;
            $display("FAIL drain: got busy after %0d cycles, want idle", guard);
        end
        repeat (2) @(negedge clk);
        chk("queue_drained", 0, 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
